// File: rtl/shreg_595_chain.sv
// ============================================================================
// Module  : shreg_595_chain
// Brief   : Serial frame driver for a daisy-chained 74HC595 shift-register chain.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module shreg_595_chain #(
  parameter int DATA_W       = 16,
  parameter int CLK_DIV      = 4,
  parameter bit MSB_FIRST    = 1'b1,
  parameter bit AUTO_REFRESH = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_shcp,
  output logic              o_stcp,
  output logic              o_ds,
  output logic              o_oe,
  output logic              o_done
);

  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [PH_W-1:0]  c_PH_LAST    = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  c_PH_HIGH    = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  c_LATCH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] c_BIT_LAST   = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PH_W-1:0]    r_phase;
  logic [PH_W-1:0]    w_phase_nxt;
  logic [BIT_W-1:0]   r_bit;
  logic [BIT_W-1:0]   w_bit_nxt;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  r_last;
  logic               r_accepted;
  logic               r_live;
  logic               r_shcp;
  logic               r_stcp;
  logic               r_oe;
  logic               r_done;
  logic               w_load_new;
  logic               w_load_last;
  logic               w_shift_bit;
  logic               w_latch_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters restart at their terminal counts, so they never wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_load_new  = 1'b0;
    w_load_last = 1'b0;
    w_shift_bit = 1'b0;
    w_latch_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_valid && r_live) begin
          w_load_new  = 1'b1;
          w_state_nxt = ST_SHIFT;
          w_phase_nxt = '0;
          w_bit_nxt   = '0;
        end else if (AUTO_REFRESH && r_accepted && !i_valid) begin
          w_load_last = 1'b1;
          w_state_nxt = ST_SHIFT;
          w_phase_nxt = '0;
          w_bit_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        if (r_phase == c_PH_LAST) begin
          w_phase_nxt = '0;
          if (r_bit == c_BIT_LAST) begin
            w_state_nxt = ST_LATCH;
          end else begin
            w_bit_nxt   = r_bit + 1'b1;
            w_shift_bit = 1'b1;
          end
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
      ST_LATCH: begin
        if (r_phase == c_LATCH_LAST) begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = '0;
          w_latch_end = 1'b1;
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_last     <= '0;
      r_accepted <= 1'b0;
      r_live     <= 1'b0;
      r_shcp     <= 1'b0;
      r_stcp     <= 1'b0;
      r_oe       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
      r_live  <= 1'b1;
      r_done  <= w_latch_end;
      if (w_latch_end) begin
        r_oe <= 1'b0;
      end
      // Shift data moves only at bit boundaries, keeping o_ds steady across each SHCP rise.
      if (w_load_new) begin
        r_shift    <= i_data;
        r_last     <= i_data;
        r_accepted <= 1'b1;
      end else if (w_load_last) begin
        r_shift <= r_last;
      end else if (w_shift_bit) begin
        r_shift <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
      end
      r_shcp <= (w_state_nxt == ST_SHIFT) && (w_phase_nxt >= c_PH_HIGH);
      r_stcp <= (w_state_nxt == ST_LATCH);
    end
  end

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign o_ds = r_shift[DATA_W-1];
    end else begin : g_lsb_first
      assign o_ds = r_shift[0];
    end
  endgenerate

  assign o_ready = r_live && (r_state == ST_IDLE);
  assign o_shcp  = r_shcp;
  assign o_stcp  = r_stcp;
  assign o_oe    = r_oe;
  assign o_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_shreg_595_chain.sv
// ============================================================================
// Module  : tb_shreg_595_chain
// Brief   : Scoreboard bench for shreg_595_chain over three parameter sets.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_shreg_595_chain;

  typedef struct {
    logic [63:0] ser;
    int          done_cyc;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [2:0]  rst_v;
  logic [2:0]  valid_v;
  logic [63:0] data_v [3];
  wire  [2:0]  rdy_v, shcp_v, stcp_v, ds_v, oe_v, done_v;

  task automatic chk(input string nm, input int g, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cfg%0d cyc=%0d actual=%0h required=%0h", nm, g, cyc, act, exp);
    end
  endtask

  // k-th bit on the wire lands at position k of the result.
  function automatic logic [63:0] ser_of(input logic [63:0] d, input int dw, input bit msb);
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < dw; k++) s[k] = msb ? d[dw-1-k] : d[k];
    return s;
  endfunction

  generate
    for (genvar G = 0; G < 3; G++) begin : g_cfg
      localparam int DW  = (G == 2) ? 1 : 16;
      localparam int CD  = (G == 2) ? 1 : 2;
      localparam bit MSB = (G == 1) ? 1'b0 : 1'b1;
      localparam bit AR  = (G == 1) ? 1'b1 : 1'b0;
      localparam int LAT = DW * 2 * CD + CD + 1;

      item_t       q[$];
      logic        m_live, m_acc;
      int          m_busy_to;
      logic [63:0] m_last;
      int          nbits, stcnt, hcnt;
      logic [63:0] cap;
      logic        prev_shcp, prev_ds, oe_exp;

      shreg_595_chain #(
        .DATA_W(DW), .CLK_DIV(CD), .MSB_FIRST(MSB), .AUTO_REFRESH(AR)
      ) u_dut (
        .clk(clk), .rst(rst_v[G]), .i_data(data_v[G][DW-1:0]), .i_valid(valid_v[G]),
        .o_ready(rdy_v[G]), .o_shcp(shcp_v[G]), .o_stcp(stcp_v[G]), .o_ds(ds_v[G]),
        .o_oe(oe_v[G]), .o_done(done_v[G])
      );

      // Reference model: a frame occupies the block for LAT cycles after acceptance.
      always @(negedge clk) begin
        item_t it;
        bit    idle;
        if (rst_v[G]) begin
          q.delete();
          m_live = 1'b0; m_acc = 1'b0; m_busy_to = 0; m_last = '0;
        end else begin
          idle = (cyc >= m_busy_to);
          chk("ready", G, rdy_v[G], idle && m_live);
          if (idle && m_live && valid_v[G]) begin
            it.ser = ser_of(data_v[G], DW, MSB);
            it.done_cyc = cyc + LAT;
            q.push_back(it);
            m_busy_to = cyc + LAT;
            m_last = data_v[G];
            m_acc = 1'b1;
          end else if (AR && idle && m_acc && !valid_v[G]) begin
            it.ser = ser_of(m_last, DW, MSB);
            it.done_cyc = cyc + LAT;
            q.push_back(it);
            m_busy_to = cyc + LAT;
          end
          m_live = 1'b1;
        end
      end

      // Monitor: captures the serial stream and retires items at their done cycle.
      always @(negedge clk) begin
        item_t it;
        bit    exp_done;
        if (rst_v[G]) begin
          chk("reset_outs", G, {rdy_v[G], oe_v[G], shcp_v[G], stcp_v[G], done_v[G], ds_v[G]}, 6'b010000);
          nbits = 0; stcnt = 0; hcnt = 0; cap = '0;
          prev_shcp = 1'b0; prev_ds = 1'b0; oe_exp = 1'b1;
        end else begin
          exp_done = (q.size() > 0) && (q[0].done_cyc == cyc);
          if (exp_done) oe_exp = 1'b0;
          chk("done", G, done_v[G], exp_done);
          chk("oe", G, oe_v[G], oe_exp);
          if (q.size() == 0) chk("idle_quiet", G, {shcp_v[G], stcp_v[G]}, 2'b00);
          if (shcp_v[G] && !prev_shcp) begin
            chk("ds_stable", G, ds_v[G], prev_ds);
            if (nbits < 64) cap[nbits] = ds_v[G];
            nbits++;
          end
          if (shcp_v[G]) begin
            hcnt++;
          end else if (prev_shcp) begin
            chk("shcp_high_len", G, hcnt, CD);
            hcnt = 0;
          end
          if (stcp_v[G]) begin
            stcnt++;
            chk("shcp_in_latch", G, shcp_v[G], 0);
          end
          if (exp_done) begin
            it = q.pop_front();
            chk("bit_count", G, nbits, DW);
            chk("bits", G, cap, it.ser);
            chk("stcp_len", G, stcnt, CD);
            nbits = 0; stcnt = 0; cap = '0;
          end
          prev_shcp = shcp_v[G];
          prev_ds   = ds_v[G];
        end
      end
    end
  endgenerate

  task automatic pause(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the offer until the DUT shows ready; return just after the handshake edge.
  task automatic offer(input int k, input logic [63:0] d);
    valid_v[k] = 1'b1;
    data_v[k]  = d;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (rdy_v[k]) begin
        @(posedge clk);
        #1;
        valid_v[k] = 1'b0;
        return;
      end
    end
    valid_v[k] = 1'b0;
    chk("handshake_timeout", k, 0, 1);
  endtask

  task automatic pulse_rst(input int k, input int n);
    rst_v[k] = 1'b1;
    pause(n);
    rst_v[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v   = 3'b111;
    valid_v = 3'b000;
    for (int k = 0; k < 3; k++) data_v[k] = '0;
    pause(3);
    rst_v = 3'b000;
    fork
      begin
        offer(0, 64'hA5C3);
        pause(80);
        offer(0, 64'h1234);
        offer(0, 64'hFFFF);
        pause(80);
        for (int i = 0; i < 12; i++) begin
          offer(0, {$urandom, $urandom});
          if ($urandom_range(0, 2) != 0) pause(60 + $urandom_range(0, 10));
        end
        pause(80);
        offer(0, 64'h5A5A);
        pause(30);
        pulse_rst(0, 3);
        offer(0, 64'hC0DE);
        pause(80);
      end
      begin
        pulse_rst(1, 2);
        pause(20);
        offer(1, 64'h0001);
        pause(300);
        offer(1, 64'h00FF);
        pause(200);
        offer(1, {32'h0, $urandom});
        pause(150);
        for (int i = 0; i < 4; i++) begin
          offer(1, {32'h0, $urandom});
          pause($urandom_range(10, 100));
        end
      end
      begin
        offer(2, 64'h1);
        pause(6);
        offer(2, 64'h0);
        pause(6);
        for (int i = 0; i < 10; i++) offer(2, {32'h0, $urandom});
        pause(10);
      end
    join
    pause(100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
